// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and request record for the byte-addressed memory unit.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // The illegal size is treated as a word so its range check stays well defined.
  function automatic logic [2:0] bytes_of(input logic [1:0] size);
    case (size)
      SZ_BYTE: bytes_of = 3'd1;
      SZ_HALF: bytes_of = 3'd2;
      default: bytes_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Big-endian lane steering: load extraction/extension and store byte enables/lane data.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]      i_size,
  input  logic            i_sign_ext,
  input  logic [1:0]      i_off,
  input  logic [3:0][7:0] i_rbytes,
  input  logic [31:0]     i_wdata,
  output logic [31:0]     o_rdata,
  output logic [3:0]      o_be,
  output logic [3:0][7:0] o_wbytes
);

  // Lane k holds the byte at offset k within the aligned word (lane 0 is the MSB).
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rbytes[i_off];
  assign w_half = {i_rbytes[{i_off[1], 1'b0}], i_rbytes[{i_off[1], 1'b1}]};

  always_comb begin
    o_rdata = '0;
    case (i_size)
      SZ_BYTE: o_rdata = {{24{i_sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: o_rdata = {{16{i_sign_ext & w_half[15]}}, w_half};
      SZ_WORD: o_rdata = {i_rbytes[0], i_rbytes[1], i_rbytes[2], i_rbytes[3]};
      default: o_rdata = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);

      assign o_be[gi] = (i_size == SZ_WORD)
                      | ((i_size == SZ_HALF) & (i_off[1] == LANE[1]))
                      | ((i_size == SZ_BYTE) & (i_off == LANE));

      // Even lane of a half takes the upper store byte.
      assign o_wbytes[gi] = (i_size == SZ_WORD)               ? i_wdata[8*(3-gi) +: 8] :
                            ((i_size == SZ_HALF) && !LANE[0]) ? i_wdata[15:8]          :
                                                                i_wdata[7:0];
    end
  endgenerate

endmodule

// File: rtl/mem_unit_ws.sv
// Byte-addressed big-endian memory with programmable wait states, req/ready handshake
// and alignment/range error reporting for the multi-cycle datapath.
module mem_unit_ws
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic        o_err_align,
  output logic        o_err_range
);

  localparam int AW = $clog2(DEPTH_BYTES);

  state_e      r_state;
  logic [3:0]  r_wait_cnt;
  req_t        r_req;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_busy;
  logic        r_err_align;
  logic        r_err_range;

  logic [7:0]  r_mem [0:DEPTH_BYTES-1];

  logic [AW-1:0]   w_base;
  logic [3:0][7:0] w_rbytes;
  logic [3:0][7:0] w_wbytes;
  logic [3:0]      w_be;
  logic [31:0]     w_ld_data;
  logic            w_err_align;
  logic            w_err_range;
  logic            w_ok;
  logic            w_store_go;

  // Legal accesses never cross a word boundary, so all four lanes share one base.
  assign w_base = r_req.addr[AW-1:0] & ~AW'(3);

  assign w_err_align = (r_req.size == SZ_ILL)
                    || ((r_req.size == SZ_HALF) && r_req.addr[0])
                    || ((r_req.size == SZ_WORD) && (r_req.addr[1:0] != 2'b00));

  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  assign w_err_range = ({1'b0, r_req.addr} + 33'(bytes_of(r_req.size))) > 33'(DEPTH_BYTES);

  assign w_ok       = !w_err_align && !w_err_range;
  assign w_store_go = (r_state == ACCESS) && r_req.we && w_ok;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd
      assign w_rbytes[gi] = r_mem[w_base | AW'(gi)];
    end
  endgenerate

  mem_align u_align (
    .i_size     (r_req.size),
    .i_sign_ext (r_req.sign_ext),
    .i_off      (r_req.addr[1:0]),
    .i_rbytes   (w_rbytes),
    .i_wdata    (r_req.wdata),
    .o_rdata    (w_ld_data),
    .o_be       (w_be),
    .o_wbytes   (w_wbytes)
  );

  always_ff @(posedge clk) begin
    if (w_store_go) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_base | AW'(k)] <= w_wbytes[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      r_req       <= '0;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_err_align <= 1'b0;
      r_err_range <= 1'b0;
    end else begin
      r_ready     <= 1'b0;
      r_err_align <= 1'b0;
      r_err_range <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_req <= '{we: i_we, size: i_size, sign_ext: i_sign_ext,
                       addr: i_addr, wdata: i_wdata};
            r_busy     <= 1'b1;
            r_wait_cnt <= '0;
            if (WAIT_STATES > 0) r_state <= WAIT;
            else                 r_state <= ACCESS;
          end
        end
        WAIT: begin
          if (r_wait_cnt == 4'(WAIT_STATES - 1)) begin
            r_wait_cnt <= '0;
            r_state    <= ACCESS;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        ACCESS: begin
          r_ready     <= 1'b1;
          r_busy      <= 1'b0;
          r_err_align <= w_err_align;
          r_err_range <= w_err_range;
          if (!r_req.we && w_ok) r_rdata <= w_ld_data;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rdata     = r_rdata;
  assign o_ready     = r_ready;
  assign o_busy      = r_busy;
  assign o_err_align = r_err_align;
  assign o_err_range = r_err_range;

endmodule
